// File: rtl/sample_strobe_gen_if.sv
// sample_strobe_gen_if: board control inputs and strobe outputs of the
// strobe generator; master is the control side, slave is the generator.
interface sample_strobe_gen_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 10
);
    logic             enable;
    logic             start;
    logic             stop;
    logic             mode;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] burst_len;
    logic             inter;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] strobe_count;

    modport master (
        output enable,
        output start,
        output stop,
        output mode,
        output div,
        output burst_len,
        input  inter,
        input  busy,
        input  done,
        input  strobe_count
    );

    modport slave (
        input  enable,
        input  start,
        input  stop,
        input  mode,
        input  div,
        input  burst_len,
        output inter,
        output busy,
        output done,
        output strobe_count
    );
endinterface

// File: rtl/sample_strobe_gen.sv
// sample_strobe_gen: divided-clock strobe producer, continuous or burst mode.
// Define STROBE_LIVE_DIV_EN to re-sample div at every period boundary.
module sample_strobe_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    sample_strobe_gen_if.slave bus
);
    localparam logic [DIV_W-1:0] ONE_D = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] period_n;
    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] phase_n;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] len_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             burst;
    logic             burst_n;
    logic             inter;
    logic             inter_n;
    logic             busy;
    logic             busy_n;
    logic             done;
    logic             done_n;

    logic [DIV_W-1:0] div_eff;
    logic [CNT_W-1:0] count_inc;
    logic             boundary;

    // A zero divide ratio behaves like one: a strobe every cycle.
    assign div_eff   = (bus.div == '0) ? ONE_D : bus.div;
    assign count_inc = count + ONE_C;
    assign boundary  = (phase == (period - ONE_D));

    always_comb begin
        state_n  = state;
        period_n = period;
        phase_n  = phase;
        len_n    = len;
        count_n  = count;
        burst_n  = burst;
        inter_n  = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && bus.enable) begin
                    period_n = div_eff;
                    len_n    = bus.burst_len;
                    burst_n  = bus.mode;
                    phase_n  = '0;
                    count_n  = '0;
                    if (bus.mode && (bus.burst_len == '0)) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_n = 1'b1;
                if (bus.stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (bus.enable) begin
                    if (boundary) begin
                        inter_n = 1'b1;
                        phase_n = '0;
                        count_n = count_inc;
`ifdef STROBE_LIVE_DIV_EN
                        period_n = div_eff;
`endif
                        // The last strobe of a burst is still emitted.
                        if (burst && (count_inc == len)) begin
                            state_n = DONE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        phase_n = phase + ONE_D;
                    end
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            period <= '0;
            phase  <= '0;
            len    <= '0;
            count  <= '0;
            burst  <= 1'b0;
            inter  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            period <= period_n;
            phase  <= phase_n;
            len    <= len_n;
            count  <= count_n;
            burst  <= burst_n;
            inter  <= inter_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    assign bus.inter        = inter;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.strobe_count = count;
endmodule

// File: tb/tb_sample_strobe_gen.sv
// tb_sample_strobe_gen: directed and random checks of sample_strobe_gen
// against a strobe-schedule reference model.
module tb_sample_strobe_gen;
    localparam int DIV_W = 16;
    localparam int CNT_W = 10;
    localparam int CMOD  = 1 << CNT_W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sample_strobe_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    sample_strobe_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int compared = 0;
    int mismatched = 0;

    // Model: a run counts enabled cycles; a strobe falls on each scheduled target.
    bit m_run = 0;
    bit m_fin = 0;
    bit m_burst = 0;
    int m_act = 0;
    int m_target = 0;
    int m_per = 0;
    int m_len = 0;
    int m_cnt = 0;
    bit e_inter = 0;
    bit e_busy = 0;
    bit e_done = 0;
    int nstr;

    function automatic int eff(int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        e_inter = 0;
        e_done  = 0;
        if (reset) begin
            m_run  = 0;
            m_fin  = 0;
            m_cnt  = 0;
            e_busy = 0;
        end else if (m_fin) begin
            m_fin  = 0;
            e_done = 1;
            e_busy = 0;
        end else if (!m_run) begin
            e_busy = 0;
            if (bus.start && bus.enable) begin
                m_per    = eff(int'(bus.div));
                m_len    = int'(bus.burst_len);
                m_burst  = bus.mode;
                m_cnt    = 0;
                m_act    = 0;
                m_target = m_per;
                if (m_burst && m_len == 0) begin
                    m_fin = 1;
                end else begin
                    m_run  = 1;
                    e_busy = 1;
                end
            end
        end else begin
            if (bus.stop) begin
                m_run  = 0;
                e_busy = 0;
            end else if (bus.enable) begin
                m_act++;
                if (m_act == m_target) begin
                    e_inter = 1;
                    m_cnt = (m_cnt + 1) % CMOD;
`ifdef STROBE_LIVE_DIV_EN
                    m_target += eff(int'(bus.div));
`else
                    m_target += m_per;
`endif
                    if (m_burst && m_cnt == m_len) begin
                        m_run  = 0;
                        m_fin  = 1;
                        e_busy = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".inter"}, 32'(bus.inter), 32'(e_inter));
        check({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
        check({tag, ".done"}, 32'(bus.done), 32'(e_done));
        check({tag, ".count"}, 32'(bus.strobe_count), 32'(m_cnt));
        if (bus.inter === 1'b1) nstr++;
    endtask

    task automatic go(int d, bit md, int bl, string tag);
        bus.div       = DIV_W'(d);
        bus.mode      = md;
        bus.burst_len = CNT_W'(bl);
        bus.enable    = 1'b1;
        bus.start     = 1'b1;
        tick(tag);
        bus.start = 1'b0;
        nstr = 0;
    endtask

    task automatic halt(string tag);
        bus.stop = 1'b1;
        tick(tag);
        bus.stop = 1'b0;
        tick(tag);
    endtask

    initial begin
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.mode      = 1'b0;
        bus.div       = '0;
        bus.burst_len = '0;
        tick("rst");
        tick("rst");
        check("rst.zero", 32'(bus.strobe_count), 32'd0);
        reset = 1'b0;
        tick("idle");

        go(4, 0, 0, "cont");
        for (int i = 1; i <= 12; i++) tick("cont");
        check("cont.inter12", 32'(bus.inter), 32'd1);
        check("cont.n", 32'(nstr), 32'd3);
        check("cont.cnt3", 32'(bus.strobe_count), 32'd3);
        check("cont.busy1", 32'(bus.busy), 32'd1);
        halt("cont");

        go(3, 1, 5, "burst");
        for (int i = 1; i <= 15; i++) tick("burst");
        check("burst.inter15", 32'(bus.inter), 32'd1);
        check("burst.n", 32'(nstr), 32'd5);
        tick("burst");
        check("burst.done", 32'(bus.done), 32'd1);
        tick("burst");
        check("burst.busy0", 32'(bus.busy), 32'd0);
        check("burst.held", 32'(bus.strobe_count), 32'd5);

        go(2, 0, 0, "pause");
        tick("pause");
        tick("pause");
        check("pause.first", 32'(bus.inter), 32'd1);
        bus.enable = 1'b0;
        nstr = 0;
        for (int i = 0; i < 7; i++) tick("pause");
        check("pause.gap", 32'(nstr), 32'd0);
        bus.enable = 1'b1;
        tick("pause");
        tick("pause");
        check("pause.resume", 32'(bus.inter), 32'd1);
        check("pause.cnt2", 32'(bus.strobe_count), 32'd2);
        halt("pause");

        go(0, 0, 0, "div0");
        for (int i = 0; i < 5; i++) tick("div0");
        check("div0.n", 32'(nstr), 32'd5);
        halt("div0");

        go(3, 1, 0, "len0");
        check("len0.inter", 32'(bus.inter), 32'd0);
        tick("len0");
        check("len0.done", 32'(bus.done), 32'd1);
        tick("len0");

        go(1, 0, 0, "wrap");
        for (int i = 0; i < 1025; i++) tick("wrap");
        check("wrap.cnt1", 32'(bus.strobe_count), 32'd1);
        halt("wrap");

        go(3, 1, 5, "stopb");
        tick("stopb");
        tick("stopb");
        bus.stop = 1'b1;
        tick("stopb");
        bus.stop = 1'b0;
        check("stopb.inter", 32'(bus.inter), 32'd0);
        check("stopb.busy", 32'(bus.busy), 32'd0);
        tick("stopb");
        check("stopb.done", 32'(bus.done), 32'd0);

        go(2, 1, 4, "rstmid");
        for (int i = 0; i < 5; i++) tick("rstmid");
        reset = 1'b1;
        tick("rstmid");
        reset = 1'b0;
        check("rstmid.busy", 32'(bus.busy), 32'd0);
        check("rstmid.cnt", 32'(bus.strobe_count), 32'd0);
        tick("rstmid");
        check("rstmid.done", 32'(bus.done), 32'd0);

        go(4, 0, 0, "restart");
        tick("restart");
        tick("restart");
        bus.start = 1'b1;
        tick("restart");
        bus.start = 1'b0;
        tick("restart");
        check("restart.inter", 32'(bus.inter), 32'd1);
        check("restart.cnt", 32'(bus.strobe_count), 32'd1);
        halt("restart");

        go(4, 0, 0, "live");
        tick("live");
        tick("live");
        bus.div = DIV_W'(2);
        tick("live");
        tick("live");
        check("live.first", 32'(bus.inter), 32'd1);
        tick("live");
        tick("live");
`ifdef STROBE_LIVE_DIV_EN
        check("live.second", 32'(bus.inter), 32'd1);
`else
        check("live.second", 32'(bus.inter), 32'd0);
`endif
        halt("live");

        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(299) == 0);
            bus.start  = ($urandom_range(9) == 0);
            bus.stop   = ($urandom_range(39) == 0);
            bus.enable = ($urandom_range(9) != 0);
            if ($urandom_range(7) == 0) begin
                bus.div       = DIV_W'($urandom_range(5));
                bus.mode      = 1'($urandom_range(1));
                bus.burst_len = CNT_W'($urandom_range(6));
            end
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sample_strobe_gen.md
Name: sample_strobe_gen

Overview:
- Generates the single-cycle `inter` strobe that the LED pulse counter consumes. It is the producer end of that strobe interface.
- Programmable clock divider drives a small FSM. Two modes: continuous strobes, or a burst of N strobes followed by a done pulse.
- Sits between board control inputs (switches/keys) and the downstream strobe consumers: LED counter and FIR sample-tick input.

Parameters:
- DIV_W, 16: width of divide ratio input and internal phase counter.
- CNT_W, 10: width of burst length and emitted-strobe counter. Matches the 10-bit LED counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  level; 0 pauses the divider in RUN
- start  input  1  single-cycle request to begin generation
- stop  input  1  single-cycle request to abort generation
- mode  input  1  0 = continuous, 1 = burst
- div  input  DIV_W  strobe period in clk cycles; 0 is treated as 1
- burst_len  input  CNT_W  strobes per burst (mode = 1)
- inter  output  1  strobe, exactly one cycle high per period
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a burst completes
- strobe_count  output  CNT_W  strobes emitted since last start

Behaviour:
- Reset: synchronous, sampled on posedge clk.
  - FSM goes to IDLE.
  - inter = 0, busy = 0, done = 0, strobe_count = 0, phase = 0.
  - Latched period and length are cleared to 0.
  - Reset mid-RUN aborts with no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start = 1 and enable = 1: latch period = max(div, 1), latch len = burst_len, latch mode.
  - Same edge: clear phase and strobe_count.
  - Next state: RUN, or DONE if mode = 1 and burst_len = 0 (no strobe is emitted).
  - start while enable = 0 is ignored.
- RUN:
  - busy = 1.
  - enable = 1: phase increments each cycle.
  - When phase == period-1: inter = 1 on the next cycle, phase returns to 0, strobe_count increments.
  - First strobe is visible exactly `period` cycles after the start edge. With period = 1, inter is high every cycle.
  - enable = 0: phase and strobe_count hold, inter = 0. Resuming continues from the held phase.
- strobe_count arithmetic: modulo 2^CNT_W; wraps from 2^CNT_W-1 to 0.
- Burst end: in mode 1, when the increment makes strobe_count == len, go to DONE. That final strobe is still emitted.
- stop in RUN: go to IDLE next cycle, no done pulse. If stop coincides with a period boundary, stop wins and no strobe is emitted.
- start while in RUN or DONE is ignored.
- div, mode and burst_len changes during RUN are ignored (values were latched at start).
- DONE: done = 1 for exactly one cycle, busy = 0, then go to IDLE. strobe_count holds its final value until the next start.
- Priority on the same edge: reset > stop > enable gating > period boundary.

Optional Feature:
- Macro: STROBE_LIVE_DIV_EN.
- Defined: period is re-sampled from div (0 treated as 1) at every period boundary and at start. A div change takes effect from the next period. The current period is never truncated.
- Undefined: period is latched only at start, as in Behaviour. The re-sample logic is absent.

Test Plan:
- Continuous rate: reset, then div = 4, mode = 0, enable = 1, pulse start. Required: inter high on cycles 4, 8, 12, … after start, each 1 cycle wide; strobe_count = 3 after cycle 12; busy = 1.
- Burst: div = 3, burst_len = 5, mode = 1, start. Required: 5 strobes, at cycles 3, 6, 9, 12, 15; done high one cycle after the 5th; busy = 0 afterwards; strobe_count = 5 held.
- Pause: div = 2, continuous. Drop enable for 7 cycles after the first strobe. Required: no strobes during the gap; next strobe 2 cycles after enable returns minus the already-elapsed phase; count continues from 1.
- Boundaries:
  - div = 0 gives a strobe every cycle.
  - burst_len = 0 in mode 1 gives no strobe and done one cycle after start.
  - CNT_W = 10 with 1025 strobes leaves strobe_count = 1.
- Abort/reset:
  - stop coincident with a period boundary gives no strobe, IDLE, done = 0.
  - reset asserted mid-burst clears all outputs next edge.
  - start during RUN has no effect on phase or count.
- Feature: with STROBE_LIVE_DIV_EN defined, change div 4→2 mid-period. Required: current period completes at 4, subsequent strobes every 2 cycles. Without the macro, period stays 4.
